// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin scheduler sharing one sequential W-bit divider among NREQ requesters.
// Define DIVSHARE_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
module div_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int PTR_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      q,
  output logic [W-1:0]      r,
  output logic              err,
  output logic              busy,
  output logic              div_start,
  output logic [W-1:0]      div_a,
  output logic [W-1:0]      div_b,
  input  logic              div_done,
  input  logic [W-1:0]      div_q,
  input  logic [W-1:0]      div_r
);

  localparam int NSLOT = 1 << PTR_W;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_arr [NSLOT];
  logic [W-1:0]     b_arr [NSLOT];
  logic [NSLOT-1:0] req_ext;
  logic [PTR_W-1:0] last, gnt, pick;
  logic             found, b_zero, first_wait, done_ok, timed_out;

  // Pointer slots beyond NREQ read as idle requesters with zero operands.
  for (genvar i = 0; i < NSLOT; i++) begin : g_unpack
    if (i < NREQ) begin : g_used
      assign a_arr[i]   = a_flat[i*W +: W];
      assign b_arr[i]   = b_flat[i*W +: W];
      assign req_ext[i] = req[i];
    end else begin : g_pad
      assign a_arr[i]   = '0;
      assign b_arr[i]   = '0;
      assign req_ext[i] = 1'b0;
    end
  end

  // Search upward from last+1 so the requester just served ends up lowest priority.
  always_comb begin
    int scan;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    found = 1'b0;
    pick  = last;
    scan  = 0;
    for (int s = 1; s <= NREQ; s++) begin
      scan = int'(last) + s;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!found && req_ext[PTR_W'(scan)]) begin
        found = 1'b1;
        pick  = PTR_W'(scan);
      end
    end
  end

  assign b_zero  = (b_arr[pick] == '0);
  // The divider still shows its stale idle-high done during the first WAIT cycle.
  assign done_ok = (state == WAIT) && !first_wait && div_done;

`ifdef DIVSHARE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wait_cnt <= '0;
    else if (state == START)                    wait_cnt <= '0;
    else if (state == WAIT && wait_cnt != '1)   wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT) && !done_ok && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = b_zero ? RESP : START;
      START:   state_nxt = WAIT;
      WAIT:    if (done_ok || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last       <= PTR_W'(NREQ - 1);
      gnt        <= '0;
      div_a      <= '0;
      div_b      <= '0;
      q          <= '0;
      r          <= '0;
      err        <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= pick;
            last  <= pick;
            div_a <= a_arr[pick];
            div_b <= b_arr[pick];
            if (b_zero) begin
              q   <= '1;
              r   <= a_arr[pick];
              err <= 1'b1;
            end
          end
        end
        START: first_wait <= 1'b1;
        WAIT: begin
          first_wait <= 1'b0;
          if (done_ok) begin
            q   <= div_q;
            r   <= div_r;
            err <= 1'b0;
          end else if (timed_out) begin
            q   <= '0;
            r   <= '0;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_start = (state == START);
  assign busy      = (state != IDLE);
  assign ack       = (state == RESP) ? (NREQ'(1) << gnt) : '0;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl with an 8-cycle divider model and a round-robin reference model.
module tb_div_share_ctrl;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_flat, b_flat;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      q, r, div_a, div_b, div_q, div_r;
  logic              err, busy, div_start, div_done;

  int tests = 0;
  int fails = 0;
  int model_last;
  logic stuck;

  always #5 clk = ~clk;

  div_share_ctrl #(.NREQ(NREQ), .W(W), .PTR_W(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .ack(ack), .q(q), .r(r), .err(err), .busy(busy),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  // 8-cycle divider: done drops the cycle after start and returns 8 cycles later.
  int dcnt;
  logic [W-1:0] dq, dr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= 0; dq <= '0; dr <= '0;
    end else if (div_start) begin
      dcnt <= 8;
      dq   <= (div_b != 0) ? div_a / div_b : '1;
      dr   <= (div_b != 0) ? div_a % div_b : div_a;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_done = !stuck && (dcnt == 0);
  assign div_q    = dq;
  assign div_r    = dr;

  typedef struct {
    int         idx;
    logic [7:0] a, b, eq, er;
    logic       eerr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
  endtask

  // Counts negedges until an ack appears; returns at the negedge where it is seen.
  task automatic wait_ack(input int max, output int n, output logic [NREQ-1:0] av,
                          output int starts, output logic [W-1:0] sa, output logic [W-1:0] sb);
    n = 0; starts = 0; av = '0; sa = '0; sb = '0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (div_start) begin
        starts++;
        sa = div_a;
        sb = div_b;
      end
      if (ack != '0) begin
        av = ack;
        check("ack_onehot", 32'($onehot(ack)), 1);
        break;
      end
    end
    check("ack_seen", 32'(av != '0), 1);
  endtask

  task automatic run_single(input string name, input int i, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input logic eerr, input int elat);
    int n, st;
    logic [NREQ-1:0] av;
    logic [W-1:0] sa, sb;
    set_op(i, a, b);
    req[i] = 1'b1;
    wait_ack(40, n, av, st, sa, sb);
    req[i] = 1'b0;
    check({name, "_ack"}, av, 1 << i);
    check({name, "_lat"}, n, elat);
    check({name, "_q"}, q, eq);
    check({name, "_r"}, r, er);
    check({name, "_err"}, err, eerr);
    check({name, "_starts"}, st, (b != 0) ? 1 : 0);
    if (b != 0) begin
      check({name, "_div_a"}, sa, a);
      check({name, "_div_b"}, sb, b);
    end
    model_last = i;
    @(negedge clk);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic rand_test(input int iters);
    logic [7:0] ra [NREQ];
    logic [7:0] rb [NREQ];
    logic [NREQ-1:0] pending, av;
    logic [W-1:0] sa, sb;
    logic [7:0] eq, er;
    int n, st, pick, elat;
    bit first;
    for (int t = 0; t < iters; t++) begin
      pending = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        ra[i] = 8'($urandom_range(0, 255));
        rb[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        set_op(i, ra[i], rb[i]);
      end
      req = pending;
      first = 1'b1;
      while (pending != '0) begin
        pick = -1;
        for (int s = 1; s <= NREQ && pick < 0; s++)
          if (pending[(model_last + s) % NREQ]) pick = (model_last + s) % NREQ;
        eq   = (rb[pick] == 0) ? 8'd255 : ra[pick] / rb[pick];
        er   = (rb[pick] == 0) ? ra[pick] : ra[pick] % rb[pick];
        elat = ((rb[pick] == 0) ? 1 : 11) + (first ? 0 : 1);
        wait_ack(40, n, av, st, sa, sb);
        check("rnd_ack", av, 1 << pick);
        check("rnd_lat", n, elat);
        check("rnd_q", q, eq);
        check("rnd_r", r, er);
        check("rnd_err", err, (rb[pick] == 0) ? 1 : 0);
        req[pick]     = 1'b0;
        pending[pick] = 1'b0;
        model_last    = pick;
        first         = 1'b0;
        if (av == '0) pending = '0;
      end
      req = '0;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    logic [7:0] all_a [NREQ];
    logic [7:0] all_b [NREQ];
    logic [7:0] all_q [NREQ];
    logic [7:0] all_r [NREQ];
    logic [NREQ-1:0] av;
    logic [W-1:0] sa, sb;
    int n, st, acks;

    vecs[0] = '{0, 8'd14,  8'd3,   8'd4,   8'd2,   1'b0};
    vecs[1] = '{2, 8'd200, 8'd0,   8'd255, 8'd200, 1'b1};
    vecs[2] = '{1, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[3] = '{3, 8'd7,   8'd200, 8'd0,   8'd7,   1'b0};
    vecs[4] = '{1, 8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[5] = '{3, 8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
    all_a = '{8'd100, 8'd9, 8'd50, 8'd255};
    all_b = '{8'd7,   8'd9, 8'd6,  8'd16};
    all_q = '{8'd14,  8'd1, 8'd8,  8'd15};
    all_r = '{8'd2,   8'd0, 8'd2,  8'd15};

    rst_n = 1'b1; req = '0; a_flat = '0; b_flat = '0; stuck = 1'b0; model_last = NREQ - 1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_err", err, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_a", div_a, 0);
    check("rst_div_b", div_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_single($sformatf("vec%0d", v), vecs[v].idx, vecs[v].a, vecs[v].b,
                 vecs[v].eq, vecs[v].er, vecs[v].eerr, (vecs[v].b == 0) ? 1 : 11);

    // Reset in the middle of WAIT.
    set_op(1, 8'd50, 8'd5);
    req[1] = 1'b1;
    repeat (5) @(negedge clk);
    check("midwait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_err", err, 0);
    check("midrst_div_a", div_a, 0);
    check("midrst_div_b", div_b, 0);
    check("midrst_start", div_start, 0);
    req = '0;
    model_last = NREQ - 1;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (14) begin
      @(negedge clk);
      if (ack != '0) acks++;
    end
    check("postrst_acks", acks, 0);
    check("postrst_busy", busy, 0);

    // All requesters at once: grants rotate 0,1,2,3.
    for (int i = 0; i < NREQ; i++) set_op(i, all_a[i], all_b[i]);
    req = '1;
    for (int k = 0; k < NREQ; k++) begin
      wait_ack(40, n, av, st, sa, sb);
      check($sformatf("rr%0d_ack", k), av, 1 << k);
      check($sformatf("rr%0d_q", k), q, all_q[k]);
      check($sformatf("rr%0d_r", k), r, all_r[k]);
      check($sformatf("rr%0d_err", k), err, 0);
      req[k] = 1'b0;
    end
    model_last = NREQ - 1;
    @(negedge clk);

    // req1 arrives during requester 0's WAIT; req0 comes back right after its ack.
    set_op(0, 8'd77, 8'd8);
    req[0] = 1'b1;
    repeat (4) @(negedge clk);
    set_op(1, 8'd33, 8'd4);
    req[1] = 1'b1;
    wait_ack(40, n, av, st, sa, sb);
    check("fair_first_ack", av, 4'b0001);
    check("fair_first_q", q, 9);
    check("fair_first_r", r, 5);
    req[0] = 1'b0;
    @(negedge clk);
    req[0] = 1'b1;
    wait_ack(40, n, av, st, sa, sb);
    check("fair_second_ack", av, 4'b0010);
    check("fair_second_q", q, 8);
    check("fair_second_r", r, 1);
    req[1] = 1'b0;
    wait_ack(40, n, av, st, sa, sb);
    check("fair_third_ack", av, 4'b0001);
    check("fair_third_q", q, 9);
    check("fair_third_r", r, 5);
    req[0] = 1'b0;
    model_last = 0;
    @(negedge clk);

    rand_test(30);

`ifdef DIVSHARE_TIMEOUT_EN
    stuck = 1'b1;
    run_single("timeout", 3, 8'd10, 8'd3, 8'd0, 8'd0, 1'b1, 17);
    stuck = 1'b0;
    run_single("after_timeout", 3, 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 11);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Round-robin scheduler that shares one 8-bit sequential shift-subtract divider among NREQ requesters.
- Arbitrates between requesters, launches the divider with a one-cycle start pulse and tracks its level-type done.
- Returns quotient and remainder to the granted requester with a one-cycle ack.
- Sits between client blocks and the divider instance. Divide-by-zero is short-circuited locally and never reaches the divider.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; must match the divider.
- PTR_W, 2, pointer width; must be ≥ clog2(NREQ).
- TIMEOUT, 15, maximum WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- a_flat  in  NREQ*W  dividends; requester i uses bits [i*W +: W].
- b_flat  in  NREQ*W  divisors; same packing.
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- q  out  W  quotient; valid while ack is high.
- r  out  W  remainder; valid while ack is high.
- err  out  1  error flag; valid while ack is high.
- busy  out  1  high in every state except IDLE.
- div_start  out  1  one-cycle start pulse to the divider.
- div_a  out  W  registered dividend to the divider.
- div_b  out  W  registered divisor to the divider.
- div_done  in  1  divider done level: high when idle, low while computing.
- div_q  in  W  divider quotient.
- div_r  in  W  divider remainder.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, last=NREQ-1.
  - ack=0, q=0, r=0, err=0, div_start=0, div_a=0, div_b=0, busy=0.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from last+1, modulo NREQ.
  - Latch gnt, div_a=a[gnt], div_b=b[gnt]; set last=gnt.
  - If b[gnt]==0, go to RESP with q=all-ones, r=a[gnt], err=1. The divider is not started.
  - Otherwise go to START.
- START:
  - div_start=1 for exactly this cycle; go to WAIT.
  - wait_cnt is cleared.
- WAIT:
  - div_done is ignored in the first WAIT cycle, because the divider still shows its stale idle-high done.
  - From the second WAIT cycle on, div_done==1 latches q=div_q, r=div_r, err=0 and goes to RESP.
  - wait_cnt increments every WAIT cycle and saturates.
- RESP:
  - ack[gnt]=1 for exactly one cycle, with q/r/err held valid; go to IDLE.
  - In every other state, ack=0; q/r/err hold their last value.
- Latency:
  - Request seen in IDLE at cycle k → div_start at cycle k+1 → ack at cycle k+11 with the 8-cycle divider.
  - Divide-by-zero: ack at cycle k+1.
- Requester protocol:
  - Hold req and operands stable until ack; deassert req in the cycle after ack.
  - Operands are latched at grant, so operand changes after grant have no effect.
  - Dropping req before ack: the transaction still completes and ack is still pulsed.
- Fairness:
  - The just-served requester has lowest priority on the next grant.
  - With all req high, grants cycle 0,1,2,3,0,…
- Simultaneous events: req arriving during START/WAIT/RESP waits; no preemption and no queueing beyond the req level.
- Reset mid-operation: immediate return to IDLE and no ack. The divider shares rst_n, so no stale done is seen after reset.
- busy=1 in START, WAIT and RESP.

Optional Feature:
- Macro: DIVSHARE_TIMEOUT_EN.
- Defined:
  - If wait_cnt reaches TIMEOUT in WAIT without div_done, go to RESP with q=0, r=0, err=1.
  - The next transaction's div_start is still issued normally.
- Undefined:
  - WAIT holds indefinitely until div_done.
  - wait_cnt logic is removed.
  - err is asserted only for divide-by-zero.

Test Plan:
- Reset with rst_n=0 mid-WAIT → all outputs 0 asynchronously; after release, busy=0 and no ack.
- req0 with a=14, b=3 → one div_start pulse; ack[0] 11 cycles after the grant cycle; q=4, r=2, err=0.
- req2 with a=200, b=0 → no div_start; ack[2] next cycle; q=255, r=200, err=1.
- req=4'b1111 held with distinct operands (a=100, b=7 / a=9, b=9 / a=50, b=6 / a=255, b=16) → acks in order 0,1,2,3:
  - q/r = 14/2, 1/0, 8/2, 15/15.
  - Exactly one ack bit high at any time.
- req1 asserted during requester 0's WAIT, and req0 re-asserted right after its ack → requester 1 is granted before requester 0.
- With DIVSHARE_TIMEOUT_EN, model div_done stuck low → ack after 15 WAIT cycles with err=1, q=0, r=0; the next request completes normally.
